seq_divider: RTL and testbench

Multi-cycle restoring divider: the inverse-operation companion to the team's 8-bit Dadda multiplier. It takes a 2·WIDTH-bit dividend and a WIDTH-bit divisor and produces a 2·WIDTH-bit quotient and a WIDTH-bit remainder. Operands and results move over valid/ready handshakes, with one quotient bit resolved per clock. It sits beside the multiplier in the arithmetic library, so a bench can check that dividing a multiplier product by one of its factors returns the other factor with zero remainder.

---
 rtl/div_pkg.sv | 12 +
 rtl/restoring_div_step.sv | 30 +++
 rtl/seq_divider.sv | 102 ++++++++++
 tb/tb_seq_divider.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and defaults for the sequential restoring divider.
package div_pkg;

  localparam int DIV_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/restoring_div_step.sv
// One restoring-division iteration, purely combinational (zero latency).
// No handshake: the caller decides when to register the step outputs.
module restoring_div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]     rem_in,
  input  logic [2*WIDTH-1:0] quo_in,
  input  logic [WIDTH-1:0]   divisor,
  output logic [WIDTH:0]     rem_out,
  output logic [2*WIDTH-1:0] quo_out
);

  logic [WIDTH:0]     shifted;
  logic [WIDTH:0]     div_ext;
  logic [2*WIDTH-1:0] quo_shift;

  assign shifted   = {rem_in[WIDTH-1:0], quo_in[2*WIDTH-1]};
  assign div_ext   = {1'b0, divisor};
  assign quo_shift = {quo_in[2*WIDTH-2:0], 1'b0};

  always_comb begin
    rem_out = shifted;
    quo_out = quo_shift;
    if (shifted >= div_ext) begin
      rem_out = shifted - div_ext;
      quo_out = quo_shift | {{(2*WIDTH-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Unsigned 2W/W restoring divider, one quotient bit per clock: result valid 2W edges after accept (0 for div-by-zero).
// Result is held in DONE until out_ready; no new operands are accepted until the result handshake completes.
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic               div_by_zero
);

  localparam int CW = $clog2(2*WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(2*WIDTH-1);

  div_state_t state, state_nxt;

  logic [CW-1:0]      cnt;
  logic [WIDTH:0]     rem_q;
  logic [2*WIDTH-1:0] quo_q;
  logic [WIDTH-1:0]   div_q;
  logic [WIDTH:0]     rem_nxt;
  logic [2*WIDTH-1:0] quo_nxt;
  logic               accept;
  logic               zero_div;

  restoring_div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem_q),
    .quo_in  (quo_q),
    .divisor (div_q),
    .rem_out (rem_nxt),
    .quo_out (quo_nxt)
  );

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign zero_div  = (divisor == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = zero_div ? DONE : BUSY;
      BUSY: if (cnt == '0) state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Result registers are only written when entering DONE, so they hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      div_q       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept && !zero_div) begin
            quo_q <= dividend;
            rem_q <= '0;
            div_q <= divisor;
            cnt   <= LAST_CNT;
          end else if (accept) begin
            quotient    <= '1;
            remainder   <= dividend[WIDTH-1:0];
            div_by_zero <= 1'b1;
          end
        end
        BUSY: begin
          rem_q <= rem_nxt;
          quo_q <= quo_nxt;
          cnt   <= cnt - CW'(1);
          if (cnt == '0) begin
            quotient    <= quo_nxt;
            remainder   <= rem_nxt[WIDTH-1:0];
            div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed table plus handshake/reset corner cases and randomised operands for seq_divider.
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        div_by_zero;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  seq_divider #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  typedef struct {
    logic [15:0] a;
    logic [7:0]  b;
    logic [15:0] q;
    logic [7:0]  r;
    logic        dz;
    int          lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Full transaction: accept, wait for result, optional stall, then handshake.
  task automatic do_op(input string name, input logic [15:0] a, input logic [7:0] b,
                       input logic [15:0] eq, input logic [7:0] er, input logic edz,
                       input int elat, input int stalls);
    int lat;
    check({name, ".in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    step();
    in_valid = 1'b0;
    dividend = ~a;
    divisor  = 8'($urandom);
    lat = 0;
    while (!out_valid && lat < 40) begin
      step();
      lat++;
    end
    if (!out_valid) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s.timeout: got no out_valid after %0d cycles, expected one", name, lat);
      return;
    end
    if (elat >= 0) check({name, ".latency"}, 32'(lat), 32'(elat));
    for (int s = 0; s < stalls; s++) begin
      check({name, ".stall_q"}, 32'(quotient), 32'(eq));
      step();
    end
    check({name, ".in_ready_done"}, 32'(in_ready), 32'd0);
    check({name, ".out_valid"}, 32'(out_valid), 32'd1);
    check({name, ".quotient"}, 32'(quotient), 32'(eq));
    check({name, ".remainder"}, 32'(remainder), 32'(er));
    check({name, ".div_by_zero"}, 32'(div_by_zero), 32'(edz));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({name, ".post_out_valid"}, 32'(out_valid), 32'd0);
    check({name, ".post_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  vec_t vecs[$];

  initial begin
    logic [15:0] a, b16, p;
    logic [7:0]  b;
    vecs.push_back('{16'd200,   8'd7,   16'd28,    8'd4,    1'b0, 16});
    vecs.push_back('{16'd65535, 8'd255, 16'd257,   8'd0,    1'b0, 16});
    vecs.push_back('{16'd1000,  8'd255, 16'd3,     8'd235,  1'b0, 16});
    vecs.push_back('{16'd5,     8'd9,   16'd0,     8'd5,    1'b0, 16});
    vecs.push_back('{16'h1234,  8'd0,   16'hFFFF,  8'h34,   1'b1, 0});
    vecs.push_back('{16'd0,     8'd5,   16'd0,     8'd0,    1'b0, 16});
    vecs.push_back('{16'd65025, 8'd255, 16'd255,   8'd0,    1'b0, 16});
    vecs.push_back('{16'd65535, 8'd1,   16'd65535, 8'd0,    1'b0, 16});
    vecs.push_back('{16'd254,   8'd255, 16'd0,     8'd254,  1'b0, 16});

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; dividend = '0; divisor = '0;
    #1;
    check("rst.in_ready", 32'(in_ready), 32'd1);
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.quotient", 32'(quotient), 32'd0);
    check("rst.remainder", 32'(remainder), 32'd0);
    check("rst.div_by_zero", 32'(div_by_zero), 32'd0);
    step(); step();
    rst = 1'b0;
    step();

    foreach (vecs[i])
      do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dz, vecs[i].lat, 0);

    // Backpressure: new operands presented during DONE must be ignored.
    in_valid = 1'b1; dividend = 16'd200; divisor = 8'd7;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 16; i++) step();
    check("bp.out_valid", 32'(out_valid), 32'd1);
    in_valid = 1'b1; dividend = 16'd5; divisor = 8'd9;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp.quotient", 32'(quotient), 32'd28);
      check("bp.remainder", 32'(remainder), 32'd4);
      check("bp.in_ready", 32'(in_ready), 32'd0);
      check("bp.out_valid_hold", 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("bp.in_ready_after", 32'(in_ready), 32'd1);
    check("bp.out_valid_after", 32'(out_valid), 32'd0);
    step();
    check("bp.no_phantom_op", 32'(in_ready), 32'd1);

    // Reset in the middle of BUSY aborts immediately.
    in_valid = 1'b1; dividend = 16'd60000; divisor = 8'd3;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) step();
    check("mid.busy", 32'(in_ready), 32'd0);
    rst = 1'b1;
    #1;
    check("mid.out_valid", 32'(out_valid), 32'd0);
    check("mid.in_ready", 32'(in_ready), 32'd1);
    step();
    rst = 1'b0;
    step();
    do_op("after_rst", 16'd65535, 8'd1, 16'd65535, 8'd0, 1'b0, 16, 0);

    for (int i = 0; i < 2000; i++) begin
      int st;
      st = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
      if (i % 4 == 0) begin
        a = 16'($urandom_range(0, 255));
        b16 = 16'($urandom_range(1, 255));
        p = a * b16;
        do_op("prod", p, b16[7:0], a, 8'd0, 1'b0, 16, st);
      end else begin
        a = 16'($urandom);
        b = (i % 50 == 1) ? 8'd0 : 8'($urandom_range(1, 255));
        if (b == 8'd0)
          do_op("rand_dz", a, b, 16'hFFFF, a[7:0], 1'b1, 0, st);
        else
          do_op("rand", a, b, a / {8'd0, b}, 8'(a % {8'd0, b}), 1'b0, 16, st);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
